// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: register/bus widths, access sizes,
// FSM state encoding and small helpers used by mem_access and mem_align.
package mem_access_pkg;

    localparam int           REG_ADDR_W   = 5;
    localparam int           REG_W        = 32;
    localparam logic [4:0]   NOP_REG_ADDR = 5'd0;
    localparam logic [31:0]  ZERO         = 32'd0;
    localparam logic         ENABLED      = 1'b1;
    localparam logic         DISABLED     = 1'b0;

    localparam int           MEM_SIZE_W   = 2;
    typedef logic [MEM_SIZE_W-1:0] mem_size_t;

    localparam mem_size_t    MEM_BYTE     = 2'b00;
    localparam mem_size_t    MEM_HALF     = 2'b01;
    localparam mem_size_t    MEM_WORD     = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_e;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: store lane steering (byte enables, replicated write data) and
// load lane extraction with sign/zero extension. Purely combinational.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [1:0]       st_off,
    input  mem_size_t        st_size,
    input  logic [REG_W-1:0] sdata,
    output logic [3:0]       be,
    output logic [REG_W-1:0] wdata,

    input  logic [1:0]       ld_off,
    input  mem_size_t        ld_size,
    input  logic             ld_unsigned,
    input  logic [REG_W-1:0] rdata,
    output logic [REG_W-1:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = sdata;
        case (st_size)
            MEM_BYTE: begin
                be    = 4'b0001 << st_off;
                wdata = {4{sdata[7:0]}};
            end
            MEM_HALF: begin
                be    = 4'b0011 << {st_off[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Half loads use the rounded lane (addr[1]) so they match the store side.
    assign ld_byte = rdata[{ld_off, 3'b000} +: 8];
    assign ld_half = rdata[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        ldata = rdata;
        case (ld_size)
            MEM_BYTE: ldata = ld_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            MEM_HALF: ldata = ld_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default:  ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: passes ALU results to MEM/WB and runs loads/stores over a
// req/gnt + rvalid bus, stalling upstream. Optional macro: MISALIGN_TRAP_EN.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | no access outstanding; ALU ops flow through
//   ST_RSP  | load granted, waiting for rvalid
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic                  regwe_i,
    input  logic [REG_W-1:0]      result_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [REG_W-1:0]      sdata_i,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [ADDR_W-1:0]     dbus_addr_o,
    output logic [3:0]            dbus_be_o,
    output logic [REG_W-1:0]      dbus_wdata_o,
    input  logic                  dbus_gnt_i,
    input  logic                  dbus_rvalid_i,
    input  logic [REG_W-1:0]      dbus_rdata_i,
`ifdef MISALIGN_TRAP_EN
    output logic                  misalign_o,
`endif
    output logic                  stall_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  regwe_o,
    output logic [REG_W-1:0]      wbdata_o
);

    state_e           state;
    logic [1:0]       lat_off;
    mem_size_t        lat_size;
    logic             lat_unsigned;

    logic             mem_op;
    logic             is_load;
    logic             trap;
    logic             access;
    logic [REG_W-1:0] ldata;

    assign mem_op  = mem_re_i | mem_we_i;
    assign is_load = mem_re_i & ~mem_we_i;

`ifdef MISALIGN_TRAP_EN
    assign trap = mem_op & is_misaligned(mem_size_i, result_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign access = mem_op & ~trap;

    // Request and stall are suppressed during reset so a mid-access reset drops the request.
    always_comb begin
        dbus_req_o = 1'b0;
        stall_o    = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    dbus_req_o = access;
                    stall_o    = access & (is_load | ~dbus_gnt_i);
                end
                ST_RSP: stall_o = ~dbus_rvalid_i;
                default: ;
            endcase
        end
    end

    assign dbus_we_o   = mem_we_i;
    assign dbus_addr_o = {result_i[ADDR_W-1:2], 2'b00};

    mem_align u_align (
        .st_off      (result_i[1:0]),
        .st_size     (mem_size_i),
        .sdata       (sdata_i),
        .be          (dbus_be_o),
        .wdata       (dbus_wdata_o),
        .ld_off      (lat_off),
        .ld_size     (lat_size),
        .ld_unsigned (lat_unsigned),
        .rdata       (dbus_rdata_i),
        .ldata       (ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rd_o         <= NOP_REG_ADDR;
            regwe_o      <= DISABLED;
            wbdata_o     <= ZERO;
            lat_off      <= 2'b00;
            lat_size     <= MEM_WORD;
            lat_unsigned <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_o   <= 1'b0;
`endif
        end else begin
            // Anything that does not complete this edge is a bubble into WB.
            regwe_o <= DISABLED;
`ifdef MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!mem_op) begin
                        rd_o     <= rd_i;
                        regwe_o  <= regwe_i;
                        wbdata_o <= result_i;
`ifdef MISALIGN_TRAP_EN
                    end else if (trap) begin
                        misalign_o <= 1'b1;
                        wbdata_o   <= result_i;
`endif
                    end else if (is_load && dbus_gnt_i) begin
                        lat_off      <= result_i[1:0];
                        lat_size     <= mem_size_i;
                        lat_unsigned <= mem_unsigned_i;
                        state        <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (dbus_rvalid_i) begin
                        rd_o     <= rd_i;
                        regwe_o  <= regwe_i;
                        wbdata_o <= ldata;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops
// compared against a size/offset arithmetic reference model.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_i;
    logic        regwe_i;
    logic [31:0] result_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [31:0] sdata_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_gnt_i;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif
    logic        stall_o;
    logic [4:0]  rd_o;
    logic        regwe_o;
    logic [31:0] wbdata_o;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;

    logic [4:0]  exp_rd;
    logic        exp_regwe;
    logic [31:0] exp_wb;
    logic        exp_mis;

    always #5 clk = ~clk;
    always @(negedge clk) if (stall_o === 1'b1) stall_cnt++;

    mem_access #(.ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_i           (rd_i),
        .regwe_i        (regwe_i),
        .result_i       (result_i),
        .mem_re_i       (mem_re_i),
        .mem_we_i       (mem_we_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .sdata_i        (sdata_i),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_be_o      (dbus_be_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_gnt_i     (dbus_gnt_i),
        .dbus_rvalid_i  (dbus_rvalid_i),
        .dbus_rdata_i   (dbus_rdata_i),
`ifdef MISALIGN_TRAP_EN
        .misalign_o     (misalign_o),
`endif
        .stall_o        (stall_o),
        .rd_o           (rd_o),
        .regwe_o        (regwe_o),
        .wbdata_o       (wbdata_o)
    );

    // Reference model: lane and extension rules in plain arithmetic.
    function automatic int m_shift(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0) return int'(off);
        if (size == 2'd1) return int'(off) & 2;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0) return 4'(1 << m_shift(size, off));
        if (size == 2'd1) return 4'(3 << m_shift(size, off));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] sd);
        if (size == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [1:0] off,
                                           input logic uns, input logic [31:0] rdata);
        int          nbytes;
        logic [31:0] v;
        logic [31:0] mask;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (nbytes == 4) return rdata;
        v    = rdata >> (8 * m_shift(size, off));
        mask = (32'h1 << (8 * nbytes)) - 32'h1;
        v    = v & mask;
        if (!uns && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return off[0];
        return off != 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag);
        check({tag, "_rd"},    32'(rd_o),     32'(exp_rd));
        check({tag, "_regwe"}, 32'(regwe_o),  32'(exp_regwe));
        check({tag, "_wb"},    wbdata_o,      exp_wb);
`ifdef MISALIGN_TRAP_EN
        check({tag, "_mis"},   32'(misalign_o), 32'(exp_mis));
`endif
        exp_mis = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [31:0] res, input logic we,
                             input logic [1:0] size, input logic [31:0] sd);
        check({tag, "_req"},  32'(dbus_req_o), 32'd1);
        check({tag, "_addr"}, dbus_addr_o,     res & 32'hFFFF_FFFC);
        check({tag, "_we"},   32'(dbus_we_o),  32'(we));
        check({tag, "_be"},   32'(dbus_be_o),  32'(m_be(size, res[1:0])));
        if (we) check({tag, "_wdata"}, dbus_wdata_o, m_wdata(size, sd));
    endtask

    // Entered at posedge+1; returns at posedge+1 just after the completion edge.
    task automatic do_op(input logic [4:0] rd, input logic rwe, input logic [31:0] res,
                         input logic re, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] sd,
                         input int gdly, input int rdly, input logic [31:0] rdat);
        rd_i = rd; regwe_i = rwe; result_i = res; mem_re_i = re; mem_we_i = we;
        mem_size_i = size; mem_unsigned_i = uns; sdata_i = sd;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = $urandom;
        if (!re && !we) begin
            // Stray bus handshakes in IDLE must be ignored.
            dbus_gnt_i = 1'($urandom_range(0, 1));
            dbus_rvalid_i = 1'($urandom_range(0, 1));
            #1;
            check("alu_stall", 32'(stall_o), 32'd0);
            check("alu_req", 32'(dbus_req_o), 32'd0);
            tick();
            dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
            exp_rd = rd; exp_regwe = rwe; exp_wb = res;
            check_wb("alu");
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if (m_misaligned(size, res[1:0])) begin
            dbus_gnt_i = 1'b1;
            #1;
            check("trap_req", 32'(dbus_req_o), 32'd0);
            check("trap_stall", 32'(stall_o), 32'd0);
            tick();
            dbus_gnt_i = 1'b0;
            exp_regwe = 1'b0; exp_wb = res; exp_mis = 1'b1;
            check_wb("trap");
            return;
        end
`endif
        for (int i = 0; i < gdly; i++) begin
            #1;
            check_req("wait", res, we, size, sd);
            check("wait_stall", 32'(stall_o), 32'd1);
            tick();
            exp_regwe = 1'b0;
            check_wb("wait");
        end
        dbus_gnt_i = 1'b1;
        #1;
        check_req("gnt", res, we, size, sd);
        check("gnt_stall", 32'(stall_o), we ? 32'd0 : 32'd1);
        tick();
        dbus_gnt_i = 1'b0;
        exp_regwe = 1'b0;
        check_wb("gnt");
        if (we) return;
        for (int j = 0; j < rdly - 1; j++) begin
            dbus_gnt_i = 1'($urandom_range(0, 1));
            #1;
            check("rsp_req", 32'(dbus_req_o), 32'd0);
            check("rsp_stall", 32'(stall_o), 32'd1);
            tick();
            dbus_gnt_i = 1'b0;
            check_wb("rsp");
        end
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i = rdat;
        #1;
        check("rv_req", 32'(dbus_req_o), 32'd0);
        check("rv_stall", 32'(stall_o), 32'd0);
        tick();
        dbus_rvalid_i = 1'b0;
        exp_rd = rd; exp_regwe = rwe; exp_wb = m_load(size, res[1:0], uns, rdat);
        check_wb("load");
    endtask

    initial begin
        exp_mis = 1'b0;
        rst = 1'b1;
        rd_i = 5'd3; regwe_i = 1'b1; result_i = 32'h40; mem_re_i = 1'b1; mem_we_i = 1'b0;
        mem_size_i = 2'd2; mem_unsigned_i = 1'b0; sdata_i = 32'd0;
        dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'd0;
        #1;
        check("rst_req", 32'(dbus_req_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        tick();
        tick();
        exp_rd = 5'd0; exp_regwe = 1'b0; exp_wb = 32'd0;
        check_wb("rst");
        rst = 1'b0;

        // ALU pass-through
        stall_cnt = 0;
        do_op(5'd5, 1'b1, 32'h1234, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 0, 1, 32'd0);
        check("alu_stall_cnt", 32'(stall_cnt), 32'd0);

        // lb signed / unsigned from 0x103
        stall_cnt = 0;
        do_op(5'd7, 1'b1, 32'h103, 1'b1, 1'b0, 2'd0, 1'b0, 32'd0, 2, 2, 32'h80FF_FFFF);
        check("lb_stall_cnt", 32'(stall_cnt), 32'd4);
        check("lb_signed", wbdata_o, 32'hFFFF_FF80);
        do_op(5'd7, 1'b1, 32'h103, 1'b1, 1'b0, 2'd0, 1'b1, 32'd0, 2, 2, 32'h80FF_FFFF);
        check("lbu", wbdata_o, 32'h0000_0080);

        // sh granted immediately
        stall_cnt = 0;
        do_op(5'd9, 1'b0, 32'h102, 1'b0, 1'b1, 2'd1, 1'b0, 32'hABCD, 0, 1, 32'd0);
        check("sh_stall_cnt", 32'(stall_cnt), 32'd0);

        // lw then ALU back-to-back
        do_op(5'd11, 1'b1, 32'h200, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0, 1, 2, 32'hDEAD_BEEF);
        do_op(5'd12, 1'b1, 32'h5555, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 0, 1, 32'd0);

        // Reset while in RSP, late rvalid afterwards
        rd_i = 5'd13; regwe_i = 1'b1; result_i = 32'h300; mem_re_i = 1'b1; mem_we_i = 1'b0;
        mem_size_i = 2'd2; dbus_gnt_i = 1'b1;
        tick();
        dbus_gnt_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_req", 32'(dbus_req_o), 32'd0);
        check("rstmid_stall", 32'(stall_o), 32'd0);
        tick();
        rst = 1'b0;
        exp_rd = 5'd0; exp_regwe = 1'b0; exp_wb = 32'd0;
        check_wb("rstmid");
        dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_2222;
        #1;
        check("late_rv_req", 32'(dbus_req_o), 32'd1);
        check("late_rv_stall", 32'(stall_o), 32'd1);
        tick();
        dbus_rvalid_i = 1'b0;
        check_wb("late_rv");

`ifdef MISALIGN_TRAP_EN
        stall_cnt = 0;
        do_op(5'd14, 1'b1, 32'h102, 1'b1, 1'b0, 2'd2, 1'b0, 32'd0, 0, 1, 32'd0);
        check("trap_stall_cnt", 32'(stall_cnt), 32'd0);
        do_op(5'd15, 1'b1, 32'h77, 1'b0, 1'b0, 2'd2, 1'b0, 32'd0, 0, 1, 32'd0);
`endif

        // Randomized mix
        for (int k = 0; k < 60; k++) begin
            int          kind;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 2));
            addr = $urandom;
            do_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), addr,
                  kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage core. It sits directly after the EX/MEM pipeline register and consumes its rd/regwe/result bundle.
- Non-memory instructions pass through to a registered MEM/WB bundle.
- Loads and stores are issued on a req/gnt + rvalid data bus. The pipeline is stalled until each access completes, and load data is aligned and extended before writeback.

Parameters:
ADDR_W, 32, data-bus address width; result_i[ADDR_W-1:0] is the effective address.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_i  in  5  destination register from EX/MEM
regwe_i  in  1  register write enable from EX/MEM
result_i  in  32  ALU result / effective address
mem_re_i  in  1  load
mem_we_i  in  1  store; has priority over mem_re_i
mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned_i  in  1  zero-extend load when 1
sdata_i  in  32  store data, right-aligned
dbus_req_o  out  1  request valid
dbus_we_o  out  1  write
dbus_addr_o  out  ADDR_W  word-aligned address {result_i[ADDR_W-1:2],2'b00}
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  lane-replicated store data
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  load data valid
dbus_rdata_i  in  32  load data
stall_o  out  1  hold upstream stages and inputs
rd_o  out  5  MEM/WB destination register
regwe_o  out  1  MEM/WB write enable
wbdata_o  out  32  MEM/WB writeback data

Behaviour:
- Reset: state IDLE; rd_o=0, regwe_o=0, wbdata_o=0. dbus_req_o and stall_o are low in the reset cycle.
- FSM states:
  - IDLE: no access outstanding.
  - RSP: load granted, awaiting rvalid.
- Non-memory op (mem_re_i=mem_we_i=0) in IDLE:
  - stall_o=0.
  - Next edge: rd_o<=rd_i, regwe_o<=regwe_i, wbdata_o<=result_i.
  - Latency 1 cycle.
- Memory op in IDLE:
  - dbus_req_o=1 combinationally; addr, be and wdata are combinational from the inputs.
  - Request is held until dbus_gnt_i. Upstream holds its inputs while stall_o=1.
- Store:
  - stall_o = !dbus_gnt_i.
  - On the grant edge: regwe_o<=0 and the state stays IDLE.
- Load:
  - stall_o=1 in IDLE.
  - On the grant edge: latch addr[1:0], size and unsigned, then go to RSP.
- RSP:
  - req=0; stall_o = !dbus_rvalid_i.
  - On the rvalid edge: rd_o<=rd_i, regwe_o<=regwe_i, wbdata_o<=extended data, then go to IDLE.
- While stalled and no completion: regwe_o<=0 each edge (bubble into WB); rd_o and wbdata_o are unchanged.
- Byte enables and store data:
  - byte: be=4'b0001<<addr[1:0]; wdata={4{sdata[7:0]}}.
  - half: be=4'b0011<<{addr[1],1'b0}; wdata={2{sdata[15:0]}}.
  - word: be=4'b1111; wdata=sdata.
- Load data: rdata>>(off*8), then sign- or zero-extend from 8/16 bits; word loads are passed unchanged.
- Bus rules:
  - rvalid arrives no earlier than the cycle after gnt.
  - rvalid in IDLE is ignored.
  - gnt in RSP is ignored.
- Reset mid-access: returns to IDLE immediately and the request is dropped. A late rvalid is then ignored.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign_o (1 bit).
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request and does not stall.
  - Next edge: misalign_o<=1 for one cycle, regwe_o<=0, wbdata_o<=result_i (faulting address).
  - misalign_o resets to 0.
- Undefined:
  - No port.
  - Misaligned accesses proceed with the rounded lanes: half uses addr[1], word ignores addr[1:0].

Decomposition:
- Shared define.vh header holds:
  - `RegAddrBus`, `RegBus`, `NopRegAddr`, `Zero`, `Enabled`/`Disabled`.
  - New: `MemSizeBus`, `MemByte`, `MemHalf`, `MemWord`, FSM state encodings.
- One natural sub-module: mem_align (combinational); covers be/wdata generation and load extraction/extension.

Test Plan:
- ALU op rd=5, regwe=1, result=0x1234, no mem -> next cycle rd_o=5, regwe_o=1, wbdata_o=0x1234, stall_o never high.
- lb from addr 0x103, rdata=0x80FFFFFF, gnt after 2 cycles, rvalid 1 cycle later -> stall_o high 4 cycles, be=0001<<3, wbdata_o=0xFFFFFF80; with mem_unsigned_i -> 0x00000080.
- sh sdata=0xABCD at 0x102, gnt same cycle -> req 1 cycle, be=1100, wdata=0xABCDABCD, stall_o low, regwe_o=0.
- lw at 0x200 then ALU op back-to-back -> load writeback then ALU writeback on consecutive completion edges, bubbles (regwe_o=0) during wait.
- rst asserted while in RSP, rvalid arrives after release -> regwe_o stays 0, state IDLE, no writeback.
- With MISALIGN_TRAP_EN, lw at 0x102 -> no dbus_req_o, misalign_o pulse 1 cycle, wbdata_o=0x102.
